ram_req_ctrl: RTL

RAM_REQ_CTRL -- requirements
Module: ram_req_ctrl

---
 rtl/ram_req_ctrl_if.sv | 36 +++
 rtl/ram_req_ctrl.sv | 106 ++++++++++
 2 files changed

// File: rtl/ram_req_ctrl_if.sv
// Request, read-response and RAM-side signals of the RAM request controller.
// The controller uses the slave modport; the requester/RAM environment uses master.
interface ram_req_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 12
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  ram_write;
  logic [ADDR_WIDTH-1:0] ram_wr_address;
  logic [DATA_WIDTH-1:0] ram_data_in;
  logic                  ram_read;
  logic [ADDR_WIDTH-1:0] ram_rd_address;
  logic [DATA_WIDTH-1:0] ram_data_out;
  logic                  busy;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rsp_ready, ram_data_out,
    input  wr_ready, rd_ready, rsp_valid, rsp_data, ram_write, ram_wr_address,
           ram_data_in, ram_read, ram_rd_address, busy
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rsp_ready, ram_data_out,
    output wr_ready, rd_ready, rsp_valid, rsp_data, ram_write, ram_wr_address,
           ram_data_in, ram_read, ram_rd_address, busy
  );
endinterface

// File: rtl/ram_req_ctrl.sv
// RAM request controller: registered write/read strobes to a 1-cycle-latency RAM,
// credit-limited read issue and an in-order read-response buffer.
module ram_req_ctrl #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned RSP_DEPTH  = 4
) (
  input  logic           clk,
  input  logic           resetn,
  ram_req_ctrl_if.slave  bus
);

  localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  logic                  ram_write_q;
  logic [ADDR_WIDTH-1:0] ram_wr_address_q;
  logic [DATA_WIDTH-1:0] ram_data_in_q;
  logic                  ram_read_q;
  logic [ADDR_WIDTH-1:0] ram_rd_address_q;
  logic                  rd_pend_q;
  logic [DATA_WIDTH-1:0] rsp_buf_q [RSP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      count_q;

  logic             hazard;
  logic             credit_ok;
  logic             wr_fire;
  logic             rd_fire;
  logic             push;
  logic             pop;
  logic [SUM_W-1:0] used;

  // Credits cover both pipeline stages of an issued read plus buffered responses.
  assign used      = SUM_W'(ram_read_q) + SUM_W'(rd_pend_q) + SUM_W'(count_q);
  assign credit_ok = (used < SUM_W'(RSP_DEPTH));
  assign hazard    = bus.wr_valid && (bus.wr_addr == bus.rd_addr);

  assign bus.wr_ready = resetn;
  assign bus.rd_ready = resetn && credit_ok && !hazard;

  assign wr_fire = bus.wr_valid && bus.wr_ready;
  assign rd_fire = bus.rd_valid && bus.rd_ready;
  assign push    = rd_pend_q;
  assign pop     = (count_q != '0) && bus.rsp_ready;

  // RAM command registers; rd_pend_q marks the cycle ram_data_out is valid.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ram_write_q      <= 1'b0;
      ram_wr_address_q <= '0;
      ram_data_in_q    <= '0;
      ram_read_q       <= 1'b0;
      ram_rd_address_q <= '0;
      rd_pend_q        <= 1'b0;
    end else begin
      ram_write_q <= wr_fire;
      if (wr_fire) begin
        ram_wr_address_q <= bus.wr_addr;
        ram_data_in_q    <= bus.wr_data;
      end
      ram_read_q <= rd_fire;
      if (rd_fire) begin
        ram_rd_address_q <= bus.rd_addr;
      end
      rd_pend_q <= ram_read_q;
    end
  end

  // Response buffer; credit accounting guarantees a free slot on every push.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(RSP_DEPTH); i++) begin
        rsp_buf_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        rsp_buf_q[wr_ptr_q] <= bus.ram_data_out;
        wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.ram_write      = ram_write_q;
  assign bus.ram_wr_address = ram_wr_address_q;
  assign bus.ram_data_in    = ram_data_in_q;
  assign bus.ram_read       = ram_read_q;
  assign bus.ram_rd_address = ram_rd_address_q;
  assign bus.rsp_valid      = (count_q != '0);
  assign bus.rsp_data       = rsp_buf_q[rd_ptr_q];
  assign bus.busy           = ram_read_q || rd_pend_q || (count_q != '0);

endmodule
